// File: rtl/vc_wrr_scheduler_if.sv
// rtl/vc_wrr_scheduler_if.sv - VC FIFO / downstream handshake bundle for the weighted round-robin scheduler
interface vc_wrr_scheduler_if;
    logic       enb;
    logic       empty_vchanel0;
    logic       empty_vchanel1;
    logic       empty_vchanel2;
    logic       empty_vchanel3;
    logic [3:0] out_vchanel0;
    logic [3:0] out_vchanel1;
    logic [3:0] out_vchanel2;
    logic [3:0] out_vchanel3;
    logic [1:0] weight_vchanel0;
    logic [1:0] weight_vchanel1;
    logic [1:0] weight_vchanel2;
    logic [1:0] weight_vchanel3;
    logic       almost_full_out;
    logic       pop_vchanel0;
    logic       pop_vchanel1;
    logic       pop_vchanel2;
    logic       pop_vchanel3;
    logic [3:0] out_wghtd_rndrobin;
    logic       valid_out;
    logic [1:0] grant_id;

    modport master (
        output enb, empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
        output out_vchanel0, out_vchanel1, out_vchanel2, out_vchanel3,
        output weight_vchanel0, weight_vchanel1, weight_vchanel2, weight_vchanel3,
        output almost_full_out,
        input  pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3,
        input  out_wghtd_rndrobin, valid_out, grant_id
    );

    modport slave (
        input  enb, empty_vchanel0, empty_vchanel1, empty_vchanel2, empty_vchanel3,
        input  out_vchanel0, out_vchanel1, out_vchanel2, out_vchanel3,
        input  weight_vchanel0, weight_vchanel1, weight_vchanel2, weight_vchanel3,
        input  almost_full_out,
        output pop_vchanel0, pop_vchanel1, pop_vchanel2, pop_vchanel3,
        output out_wghtd_rndrobin, valid_out, grant_id
    );
endinterface

// File: rtl/vc_wrr_scheduler.sv
// rtl/vc_wrr_scheduler.sv - work-conserving weighted round-robin pop scheduler over four VC FIFOs
module vc_wrr_scheduler (
    input  logic              clk,
    input  logic              rst,
    vc_wrr_scheduler_if.slave bus
);

    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [3:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic [1:0]      grant_q, grant_d;

    logic [3:0]      empty_vec;
    logic [3:0][3:0] data_vec;
    logic [3:0][1:0] weight_vec;
    logic            go;
    logic            found;
    logic [1:0]      g;
    logic [1:0]      idx;
    logic [1:0]      used;
    logic            pop_en;
    logic [3:0]      pop_vec;

    assign empty_vec  = {bus.empty_vchanel3, bus.empty_vchanel2, bus.empty_vchanel1, bus.empty_vchanel0};
    assign data_vec   = {bus.out_vchanel3, bus.out_vchanel2, bus.out_vchanel1, bus.out_vchanel0};
    assign weight_vec = {bus.weight_vchanel3, bus.weight_vchanel2, bus.weight_vchanel1, bus.weight_vchanel0};

    // rst participates in go so pops drop the instant reset asserts, not at the next edge
    assign go = rst & bus.enb & ~bus.almost_full_out;

    always_comb begin
        found = 1'b0;
        g     = ptr_q;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && !empty_vec[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    assign pop_en  = go & found;
    assign pop_vec = pop_en ? (4'b0001 << g) : 4'b0000;
    assign used    = (g == ptr_q) ? cnt_q : 2'd0;

    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        grant_d = grant_q;
        valid_d = 1'b0;
        if (pop_en) begin
            data_d  = data_vec[g];
            grant_d = g;
            valid_d = 1'b1;
            // a grant to a VC other than ptr starts a fresh turn; skipped VCs forfeit theirs
            if (used >= weight_vec[g]) begin
                ptr_d = g + 2'd1;
                cnt_d = 2'd0;
            end else begin
                ptr_d = g;
                cnt_d = used + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= 2'd0;
            cnt_q   <= 2'd0;
            data_q  <= 4'h0;
            valid_q <= 1'b0;
            grant_q <= 2'd0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
        end
    end

    assign bus.pop_vchanel0       = pop_vec[0];
    assign bus.pop_vchanel1       = pop_vec[1];
    assign bus.pop_vchanel2       = pop_vec[2];
    assign bus.pop_vchanel3       = pop_vec[3];
    assign bus.out_wghtd_rndrobin = data_q;
    assign bus.valid_out          = valid_q;
    assign bus.grant_id           = grant_q;

endmodule

// File: doc/vc_wrr_scheduler.md
VC_WRR_SCHEDULER -- requirements
Module: vc_wrr_scheduler

Interface
REQ-001 clk  input  1  sole clock; all state updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
REQ-003 enb  input  1  scheduler enable; 0 = no pops, state frozen.
REQ-004 empty_vchanel0..3  input  1 each  VC FIFO empty flags; 1 = no data.
REQ-005 out_vchanel0..3  input  4 each  VC FIFO head data (first-word-fall-through, valid whenever not empty).
REQ-006 weight_vchanel0..3  input  2 each  per-VC weight; pops per turn = weight+1 (1..4); sampled live every cycle.
REQ-007 almost_full_out  input  1  downstream backpressure; 1 = no pops this cycle.
REQ-008 pop_vchanel0..3  output  1 each  combinational pop strobes to the VC FIFOs; at most one high per cycle.
REQ-009 out_wghtd_rndrobin  output  4  registered scheduled data word.
REQ-010 valid_out  output  1  registered; 1 = out_wghtd_rndrobin carries a word popped on the previous edge.
REQ-011 grant_id  output  2  registered index of the VC that supplied the current word.

Function
REQ-012 State: ptr[1:0] (VC owning the current turn) and cnt[1:0] (pops already given to ptr this turn).
REQ-013 go = rst & enb & ~almost_full_out; when go=0 all pop_vchanelX SHALL be 0.
REQ-014 Candidate g = first VC with empty=0 searching circularly ptr, ptr+1, ptr+2, ptr+3 (mod 4); none = all empty.
REQ-015 If go=1 and a candidate exists, pop_vchanel[g] SHALL be 1 in the same cycle; otherwise all pops 0.
REQ-016 On a pop edge: used = (g==ptr) ? cnt : 0; if used >= weight[g] then ptr <= g+1 mod 4, cnt <= 0; else ptr <= g, cnt <= used+1.
REQ-017 Weight lowered mid-turn below cnt: turn ends on the next pop from that VC (>= comparison, REQ-016).
REQ-018 On a pop edge: out_wghtd_rndrobin <= out_vchanel[g], grant_id <= g, valid_out <= 1; latency pop-to-valid = 1 cycle.
REQ-019 On a non-pop edge (go=0 or all empty): valid_out <= 0; ptr, cnt, out_wghtd_rndrobin, grant_id hold.
REQ-020 Empty VCs are skipped with no idle cycle (work-conserving); a skipped VC forfeits its turn.
REQ-021 A VC emptying mid-turn: the next non-empty VC is granted in the following cycle with a fresh turn (used=0).
REQ-022 ptr wraps 3 -> 0; cnt never exceeds 3.
REQ-023 Single active VC: granted every go cycle, turns restart on itself (ptr wraps back via search).
REQ-024 pop strobes SHALL depend only on current state and current inputs (no extra registered latency).

Reset
REQ-025 While rst=0: ptr=0, cnt=0, out_wghtd_rndrobin=4'h0, valid_out=0, grant_id=0, all pops 0.
REQ-026 Reset asserted mid-turn discards the turn; after release, arbitration restarts at VC0 with cnt=0.
REQ-027 First pop may occur on the first rising edge with rst=1.

Verification
REQ-028 All weights 0, all VCs non-empty, go=1 -> grant_id sequence 0,1,2,3,0,... one word per cycle, valid_out=1 continuous.
REQ-029 Weights {3,1,0,2}, all non-empty -> per round: 4x VC0, 2x VC1, 1x VC2, 3x VC3, repeating.
REQ-030 Only VC2 non-empty, weight 1 -> pop_vchanel2 every cycle, grant_id=2, no idle cycles.
REQ-031 almost_full_out=1 for 3 cycles mid-turn of VC1 (cnt=1) -> no pops, valid_out=0, ptr/cnt held; resumes VC1 with cnt=1.
REQ-032 VC0 weight 3 empties after 2 pops, VC1 non-empty -> next cycle pops VC1 with a fresh turn.
REQ-033 rst driven 0 between clock edges during a turn -> outputs cleared immediately; after release first grant is the lowest non-empty VC from 0.
